// File: rtl/fifo_fwft_prog.sv
// -----------------------------------------------------------------------------
// fifo_fwft_prog
//
// First-word-fall-through FIFO with runtime-programmable almost-full /
// almost-empty thresholds, exact occupancy count, synchronous flush and
// sticky overflow/underflow flags.
//
// The head word is held in an output register (dataout) that is loaded from
// the storage array through a registered read port. count covers every word
// accepted and not yet popped, including the one sitting in dataout.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of contents, pointers and error flags
//   wren/datain   write request / write data (dropped while full)
//   full          no space left
//   almost_full   registered: count >= af_thresh
//   rden          pop request, acknowledges the current dataout
//   dataout       head word, valid whenever empty = 0
//   empty         no valid head word
//   almost_empty  registered: count <= ae_thresh
//   count         words accepted and not yet popped
//   af_thresh     almost-full threshold (quasi-static)
//   ae_thresh     almost-empty threshold (quasi-static)
//   clr_err       clears overflow/underflow
//   overflow      sticky: wren seen while full
//   underflow     sticky: rden seen while empty
// -----------------------------------------------------------------------------
module fifo_fwft_prog #(
   parameter int C_DATA_WIDTH = 128,
   parameter int C_FIFO_DEPTH = 16,
   parameter int C_CNT_WIDTH  = $clog2((C_FIFO_DEPTH < 2) ? 2 : C_FIFO_DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    wren,
   input  logic [C_DATA_WIDTH-1:0] datain,
   output logic                    full,
   output logic                    almost_full,
   input  logic                    rden,
   output logic [C_DATA_WIDTH-1:0] dataout,
   output logic                    empty,
   output logic                    almost_empty,
   output logic [C_CNT_WIDTH-1:0]  count,
   input  logic [C_CNT_WIDTH-1:0]  af_thresh,
   input  logic [C_CNT_WIDTH-1:0]  ae_thresh,
   input  logic                    clr_err,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int DEPTH = (C_FIFO_DEPTH < 2) ? 2 : C_FIFO_DEPTH;
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [C_CNT_WIDTH-1:0] DEPTH_C  = C_CNT_WIDTH'(DEPTH);
   localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(DEPTH - 1);

   logic [C_DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [C_CNT_WIDTH-1:0]  count_q;
   logic [C_CNT_WIDTH-1:0]  count_nxt;
   logic [C_DATA_WIDTH-1:0] dout_q;
   logic                    out_valid;
   logic                    full_q;
   logic                    af_q;
   logic                    ae_q;
   logic                    ovf_q;
   logic                    unf_q;

   logic                    write_allow;
   logic                    read_allow;
   logic                    ovf_set;
   logic                    unf_set;
   logic                    mem_has_word;
   logic                    load_head;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Flush overrides any request in its cycle, so nothing is accepted and
   // nothing is flagged.
   assign write_allow = wren & ~full_q & ~flush;
   assign read_allow  = rden & out_valid & ~flush;
   assign ovf_set     = wren & full_q & ~flush;
   assign unf_set     = rden & ~out_valid & ~flush;

   // Words still in the array = count minus the one held in dataout. Only
   // words already stored before this edge can be loaded; a word written on
   // this edge reaches dataout one edge later.
   assign mem_has_word = (count_q != {{(C_CNT_WIDTH-1){1'b0}}, out_valid});

   // Refill the head register whenever it is empty or being popped, which
   // gives bubble-free back-to-back pops when count >= 2.
   assign load_head = ~flush & (~out_valid | read_allow) & mem_has_word;

   always_comb begin
      count_nxt = count_q;
      if (flush) begin
         count_nxt = '0;
      end else begin
         unique case ({write_allow, read_allow})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
         endcase
      end
   end

   // Storage array: no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (write_allow) begin
         mem[wr_ptr] <= datain;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         dout_q    <= '0;
         out_valid <= 1'b0;
         full_q    <= 1'b0;
         af_q      <= 1'b0;
         ae_q      <= 1'b1;
      end else begin
         count_q <= count_nxt;
         full_q  <= (count_nxt == DEPTH_C);
         af_q    <= (count_nxt >= af_thresh);
         ae_q    <= (count_nxt <= ae_thresh);

         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
         end else begin
            if (write_allow) begin
               wr_ptr <= ptr_inc(wr_ptr);
            end
            // rd_ptr always points at the next word to present, so it
            // advances as the head register is loaded.
            if (load_head) begin
               dout_q    <= mem[rd_ptr];
               rd_ptr    <= ptr_inc(rd_ptr);
               out_valid <= 1'b1;
            end else if (read_allow) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   // Sticky error flags: a set wins over clr_err in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (flush) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (clr_err) begin
            ovf_q <= 1'b0;
         end
         if (unf_set) begin
            unf_q <= 1'b1;
         end else if (clr_err) begin
            unf_q <= 1'b0;
         end
      end
   end

   assign dataout      = dout_q;
   assign empty        = ~out_valid;
   assign full         = full_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_fwft_prog.sv
module tb_fifo_fwft_prog;

   logic         clk = 1'b0;
   logic         rst_n;

   // depth 16, width 128 instance
   logic         flush, wren, rden, clr_err;
   logic [127:0] datain, dataout;
   logic         full, almost_full, empty, almost_empty, overflow, underflow;
   logic [4:0]   count, af_thresh, ae_thresh;

   // depth 5, width 8 instance
   logic         flush5, wren5, rden5, clr_err5;
   logic [7:0]   din5, dout5;
   logic         full5, af5o, empty5, ae5o, ovf5, unf5;
   logic [3:0]   count5, af5, ae5;

   int n_checks = 0;
   int n_err    = 0;
   int exp_v;
   int nxt_v;

   always #5 clk = ~clk;

   fifo_fwft_prog #(.C_DATA_WIDTH(128), .C_FIFO_DEPTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wren(wren), .datain(datain),
      .full(full), .almost_full(almost_full), .rden(rden), .dataout(dataout),
      .empty(empty), .almost_empty(almost_empty), .count(count),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
      .overflow(overflow), .underflow(underflow)
   );

   fifo_fwft_prog #(.C_DATA_WIDTH(8), .C_FIFO_DEPTH(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .flush(flush5), .wren(wren5), .datain(din5),
      .full(full5), .almost_full(af5o), .rden(rden5), .dataout(dout5),
      .empty(empty5), .almost_empty(ae5o), .count(count5),
      .af_thresh(af5), .ae_thresh(ae5), .clr_err(clr_err5),
      .overflow(ovf5), .underflow(unf5)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 0; wren = 0; rden = 0; clr_err = 0; datain = '0;
      af_thresh = 5'd12; ae_thresh = 5'd2;
      flush5 = 0; wren5 = 0; rden5 = 0; clr_err5 = 0; din5 = '0;
      af5 = 4'd4; ae5 = 4'd1;
      #12;
      chk("rst_empty", 128'(empty), 128'(1));
      chk("rst_full", 128'(full), 128'(0));
      chk("rst_af", 128'(almost_full), 128'(0));
      chk("rst_ae", 128'(almost_empty), 128'(1));
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_ovf", 128'(overflow), 128'(0));
      chk("rst_unf", 128'(underflow), 128'(0));
      chk("rst_dout", dataout, 128'(0));
      rst_n = 1'b1;
      tick();

      // Fill 1..16, then a 17th write overflows
      for (int i = 1; i <= 16; i++) begin
         wren = 1; datain = 128'(i);
         tick();
         chk("fill_count", 128'(count), 128'(i));
         chk("fill_full", 128'(full), 128'(i == 16));
         chk("fill_af", 128'(almost_full), 128'(i >= 12));
         chk("fill_empty", 128'(empty), 128'(i == 1));
         chk("fill_ae", 128'(almost_empty), 128'(i <= 2));
      end
      datain = 128'h11;
      tick();
      wren = 0;
      chk("ovf_set", 128'(overflow), 128'(1));
      chk("ovf_count", 128'(count), 128'(16));
      chk("ovf_full", 128'(full), 128'(1));
      for (int i = 1; i <= 16; i++) begin
         rden = 1;
         chk("drain_data", dataout, 128'(i));
         tick();
         chk("drain_count", 128'(count), 128'(16 - i));
         chk("drain_full", 128'(full), 128'(0));
      end
      rden = 0;
      chk("drain_empty", 128'(empty), 128'(1));
      chk("drain_unf", 128'(underflow), 128'(0));
      chk("ovf_sticky", 128'(overflow), 128'(1));
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("ovf_clr", 128'(overflow), 128'(0));

      // Single word fall-through latency
      wren = 1; datain = 128'hA5;
      tick();
      wren = 0;
      chk("fwft_cnt0", 128'(count), 128'(1));
      chk("fwft_emp0", 128'(empty), 128'(1));
      tick();
      chk("fwft_emp1", 128'(empty), 128'(0));
      chk("fwft_data", dataout, 128'hA5);
      chk("fwft_cnt1", 128'(count), 128'(1));
      rden = 1;
      tick();
      rden = 0;
      chk("fwft_pop_emp", 128'(empty), 128'(1));
      chk("fwft_pop_cnt", 128'(count), 128'(0));

      // Three words, then 20 cycles of simultaneous write+read
      for (int i = 0; i < 3; i++) begin
         wren = 1; datain = 128'(32'h100 + i);
         tick();
      end
      wren = 0;
      tick();
      chk("sim_pre_cnt", 128'(count), 128'(3));
      for (int k = 0; k < 20; k++) begin
         wren = 1; rden = 1; datain = 128'(32'h103 + k);
         chk("sim_data", dataout, 128'(32'h100 + k));
         tick();
         chk("sim_cnt", 128'(count), 128'(3));
         chk("sim_emp", 128'(empty), 128'(0));
      end
      wren = 0;
      for (int i = 0; i < 3; i++) begin
         rden = 1;
         chk("sim_tail", dataout, 128'(32'h114 + i));
         tick();
      end
      rden = 0;
      chk("sim_end_emp", 128'(empty), 128'(1));
      chk("sim_end_unf", 128'(underflow), 128'(0));

      // Write+read at count 1: empty pulses for one cycle
      wren = 1; datain = 128'hB0;
      tick();
      wren = 0;
      tick();
      wren = 1; rden = 1; datain = 128'hB1;
      tick();
      wren = 0; rden = 0;
      chk("c1_emp_pulse", 128'(empty), 128'(1));
      chk("c1_cnt", 128'(count), 128'(1));
      tick();
      chk("c1_emp_back", 128'(empty), 128'(0));
      chk("c1_data", dataout, 128'hB1);
      rden = 1;
      tick();
      rden = 0;
      chk("c1_final_emp", 128'(empty), 128'(1));

      // Flush with concurrent requests, then underflow handling
      for (int i = 0; i < 10; i++) begin
         wren = 1; datain = 128'(32'h300 + i);
         tick();
      end
      wren = 0;
      chk("fl_pre_cnt", 128'(count), 128'(10));
      flush = 1; wren = 1; rden = 1;
      tick();
      flush = 0; wren = 0; rden = 0;
      chk("fl_cnt", 128'(count), 128'(0));
      chk("fl_emp", 128'(empty), 128'(1));
      chk("fl_full", 128'(full), 128'(0));
      chk("fl_ae", 128'(almost_empty), 128'(1));
      chk("fl_af", 128'(almost_full), 128'(0));
      chk("fl_ovf", 128'(overflow), 128'(0));
      chk("fl_unf", 128'(underflow), 128'(0));
      rden = 1;
      tick();
      rden = 0;
      chk("unf_set", 128'(underflow), 128'(1));
      chk("unf_cnt", 128'(count), 128'(0));
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("unf_clr", 128'(underflow), 128'(0));
      rden = 1; clr_err = 1;
      tick();
      rden = 0; clr_err = 0;
      chk("unf_set_wins", 128'(underflow), 128'(1));
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("unf_clr2", 128'(underflow), 128'(0));

      // Threshold boundaries
      af_thresh = 5'd0; ae_thresh = 5'd0;
      tick();
      chk("th_af0", 128'(almost_full), 128'(1));
      chk("th_ae0", 128'(almost_empty), 128'(1));
      wren = 1; datain = 128'hEE;
      tick();
      wren = 0;
      chk("th_ae0_c1", 128'(almost_empty), 128'(0));
      chk("th_af0_c1", 128'(almost_full), 128'(1));
      af_thresh = 5'd12; ae_thresh = 5'd2;
      tick();
      chk("th_af_rest", 128'(almost_full), 128'(0));
      chk("th_ae_rest", 128'(almost_empty), 128'(1));
      chk("th_emp", 128'(empty), 128'(0));
      rden = 1;
      tick();
      rden = 0;
      chk("th_pop_emp", 128'(empty), 128'(1));

      // Asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) begin
         wren = 1; datain = 128'(32'h200 + i);
         tick();
      end
      wren = 0;
      tick();
      chk("ar_pre_cnt", 128'(count), 128'(7));
      chk("ar_pre_emp", 128'(empty), 128'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cnt", 128'(count), 128'(0));
      chk("ar_emp", 128'(empty), 128'(1));
      chk("ar_full", 128'(full), 128'(0));
      chk("ar_ae", 128'(almost_empty), 128'(1));
      chk("ar_af", 128'(almost_full), 128'(0));
      chk("ar_dout", dataout, 128'(0));
      #2 rst_n = 1'b1;
      tick();
      wren = 1; datain = 128'hC3;
      tick();
      wren = 0;
      chk("ar_w_cnt", 128'(count), 128'(1));
      chk("ar_w_emp0", 128'(empty), 128'(1));
      tick();
      chk("ar_w_emp1", 128'(empty), 128'(0));
      chk("ar_w_data", dataout, 128'hC3);

      // Depth 5: fill, interleave across the wrap, drain
      for (int i = 1; i <= 5; i++) begin
         wren5 = 1; din5 = 8'(i);
         tick();
         chk("d5_fill_cnt", 128'(count5), 128'(i));
         chk("d5_fill_full", 128'(full5), 128'(i == 5));
         chk("d5_fill_af", 128'(af5o), 128'(i >= 4));
      end
      wren5 = 0;
      exp_v = 1;
      nxt_v = 6;
      for (int k = 0; k < 12; k++) begin
         if ((k % 2) == 0) begin
            rden5 = 1;
            chk("d5_il_data", 128'(dout5), 128'(exp_v));
            tick();
            rden5 = 0;
            exp_v++;
            chk("d5_il_full0", 128'(full5), 128'(0));
            chk("d5_il_cnt4", 128'(count5), 128'(4));
         end else begin
            wren5 = 1; din5 = 8'(nxt_v);
            tick();
            wren5 = 0;
            nxt_v++;
            chk("d5_il_full1", 128'(full5), 128'(1));
            chk("d5_il_cnt5", 128'(count5), 128'(5));
         end
      end
      for (int i = 0; i < 5; i++) begin
         rden5 = 1;
         chk("d5_drain", 128'(dout5), 128'(exp_v));
         tick();
         exp_v++;
      end
      rden5 = 0;
      chk("d5_emp", 128'(empty5), 128'(1));
      chk("d5_cnt", 128'(count5), 128'(0));
      chk("d5_ovf", 128'(ovf5), 128'(0));
      chk("d5_unf", 128'(unf5), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_fwft_prog.md
Name: fifo_fwft_prog

Overview:
Parametrised first-word-fall-through FIFO, the successor to the fixed-threshold FWFT buffer used between producer and consumer stages of the datapath.
- Adds runtime-programmable almost-full and almost-empty thresholds.
- Adds an exact occupancy count output.
- Adds a synchronous flush.
- Adds sticky overflow and underflow error flags, so control logic can detect and recover from handshake violations.
- Storage is an inferred register/RAM array with a registered read port.

Parameters:
C_DATA_WIDTH, 128, width of datain/dataout in bits (>=1)
C_FIFO_DEPTH, 16, number of storage words; values <2 are forced to 2; non-power-of-two allowed
C_CNT_WIDTH, derived = clog2(depth)+1, width of count and threshold ports (not user-set)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and pointers
wren  in  1  write request
datain  in  C_DATA_WIDTH  write data
full  out  1  no space; writes ignored
almost_full  out  1  count >= af_thresh
rden  in  1  pop request (acknowledges current dataout)
dataout  out  C_DATA_WIDTH  head word, valid whenever empty=0
empty  out  1  no valid head word
almost_empty  out  1  count <= ae_thresh
count  out  C_CNT_WIDTH  words accepted and not yet popped
af_thresh  in  C_CNT_WIDTH  almost-full threshold, quasi-static
ae_thresh  in  C_CNT_WIDTH  almost-empty threshold, quasi-static
clr_err  in  1  clears overflow/underflow
overflow  out  1  sticky: wren seen while full
underflow  out  1  sticky: rden seen while empty

Behaviour:
Reset (rst_n=0, asynchronous):
- Pointers, count = 0.
- empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, dataout=0.
- Memory contents are not reset.

Handshake:
- write_allow = wren & ~full. read_allow = rden & ~empty.
- Disallowed requests are dropped and set the matching sticky flag on the same edge.
- Overflow/underflow are cleared by clr_err or flush. A set and a clear in the same cycle resolves to set.

Count:
- +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Registered; reflects the edge on which the access occurred.
- Never exceeds depth and never wraps.

FWFT latency:
- A word written at edge N into an empty FIFO drives dataout from edge N+1; empty falls at edge N+1.
- On that edge count is already 1, so count=1 with empty=0 one cycle after the write.
- Back-to-back pops: after read_allow at edge M, the next word is on dataout at edge M with no bubble when count>=2.

Simultaneous write+read:
- count 1: the popped word leaves; the new word falls through. empty pulses high for exactly one cycle, then deasserts.
- count 0: the read is disallowed; treated as a write only.

Full:
- Asserts on the edge where a write-only access makes count = depth.
- Deasserts on the edge of any read_allow.
- A write+read while full is impossible because write_allow=0; it is a read only.

Pointers:
- Wrap from depth-1 to 0, including for non-power-of-two depth.
- Read pointer is pre-incremented so the registered read port presents the next head without a bubble.

Thresholds:
- almost_full and almost_empty are registered and compare the next count against the thresholds.
- They are valid on the same edge as count.
- Threshold changes take effect one cycle after the change.
- af_thresh=0 forces almost_full=1. af_thresh>depth makes almost_full never assert. ae_thresh>=depth makes almost_empty always 1.

Flush:
- Highest priority; overrides wren/rden in the same cycle.
- Next edge: count=0, empty=1, full=0, almost_empty=1, almost_full=(af_thresh==0), errors cleared.
- Requests in the flush cycle are not flagged as errors.

Test Plan:
- Depth 16, width 128, af=12, ae=2. Write 0x1..0x10 back-to-back: full rises on the edge of the 16th write; almost_full rises on the 12th; count=16; a 17th write sets overflow and is dropped.
- Write one word 0xA5 into an empty FIFO: empty falls and dataout=0xA5 one clock after the write edge; count=1; rden for one cycle returns to empty=1, count=0.
- Fill 3 words, then hold wren and rden together for 20 cycles with an incrementing pattern: count stays 3, empty stays 0, output sequence is exact and in order.
- Depth 5 (non-power-of-two): 12 interleaved write/read cycles crossing the wrap twice; data ordering is exact and full asserts at count 5.
- Fill 10 words, assert flush together with wren and rden: next edge count=0, empty=1, no error flags set. rden on the empty FIFO sets underflow; clr_err clears it.
- Assert rst_n low mid-stream with count=7, asynchronously and between clock edges: outputs take their reset values immediately; after release, the first new write behaves as in the empty-FIFO scenario.
